universal_ff_bank: RTL

UNIVERSAL_FF_BANK -- requirements
Module: universal_ff_bank

---
 rtl/universal_ff_bank.sv | 83 ++++++++
 1 files changed

// File: rtl/universal_ff_bank.sv
// Bank of WIDTH flip-flops acting as SR, JK, D or T with illegal-SR tracking.
// Define UFF_ILLEGAL_CNT_EN to add the saturating illegal_cnt port and counter.
module universal_ff_bank #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             clr_sticky,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qb,
    output logic             illegal,
`ifdef UFF_ILLEGAL_CNT_EN
    output logic             illegal_sticky,
    output logic [CNT_W-1:0] illegal_cnt
`else
    output logic             illegal_sticky
`endif
);

    typedef enum logic [1:0] {
        MODE_SR = 2'b00,
        MODE_JK = 2'b01,
        MODE_D  = 2'b10,
        MODE_T  = 2'b11
    } mode_t;

    logic [WIDTH-1:0] next_q;
    logic             event_hit;

    assign qb = ~q;

    // SR 11 resolves to hold, so q stays a clean 0/1 value.
    always_comb begin
        next_q = q;
        unique case (mode_t'(mode))
            MODE_SR: next_q = (a & ~b) | (q & ~(a ^ b));
            MODE_JK: next_q = (a & ~q) | (~b & q);
            MODE_D:  next_q = a;
            MODE_T:  next_q = q ^ a;
            default: next_q = q;
        endcase
    end

    assign event_hit = en && (mode_t'(mode) == MODE_SR) && (|(a & b));

    always_ff @(posedge clk) begin
        if (rst) begin
            q              <= '0;
            illegal        <= 1'b0;
            illegal_sticky <= 1'b0;
        end else begin
            illegal <= event_hit;
            if (en) begin
                q <= next_q;
            end
            if (event_hit) begin
                illegal_sticky <= 1'b1;
            end else if (clr_sticky) begin
                illegal_sticky <= 1'b0;
            end
        end
    end

`ifdef UFF_ILLEGAL_CNT_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    always_ff @(posedge clk) begin
        if (rst) begin
            illegal_cnt <= '0;
        end else if (clr_sticky) begin
            illegal_cnt <= event_hit ? CNT_W'(1) : '0;
        end else if (event_hit && (illegal_cnt != CNT_MAX)) begin
            illegal_cnt <= illegal_cnt + CNT_W'(1);
        end
    end
`endif

endmodule
